// File: rtl/rv_decode_stage.sv
// rv_decode_stage: registered RV32I instruction-decode stage with valid/ready on both sides.
// Decode happens on the way in; an output register plus one skid register hold decoded entries.
module rv_decode_stage #(
    parameter int XLEN         = 32,
    parameter bit ENABLE_M     = 1'b0,
    parameter bit PASS_ILLEGAL = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [4:0]      out_rd,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [XLEN-1:0] out_imm,
    output logic [3:0]      out_class,
    output logic [2:0]      out_funct3,
    output logic            out_alu_alt,
    output logic            out_alu_src,
    output logic            out_is_muldiv,
    output logic            out_illegal
);

    typedef enum logic [3:0] {
        CL_LUI     = 4'd0,
        CL_AUIPC   = 4'd1,
        CL_JAL     = 4'd2,
        CL_JALR    = 4'd3,
        CL_BRANCH  = 4'd4,
        CL_LOAD    = 4'd5,
        CL_STORE   = 4'd6,
        CL_OP_IMM  = 4'd7,
        CL_OP      = 4'd8,
        CL_FENCE   = 4'd9,
        CL_SYSTEM  = 4'd10,
        CL_ILLEGAL = 4'd15
    } class_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [XLEN-1:0] imm;
        class_e          cls;
        logic [2:0]      funct3;
        logic            alu_alt;
        logic            alu_src;
        logic            is_muldiv;
        logic            illegal;
    } entry_t;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    logic [6:0]  w_opcode;
    logic [2:0]  w_funct3;
    logic [6:0]  w_funct7;
    logic [5:0]  w_shift_hi;
    logic        w_shamt_ok;
    logic [31:0] w_imm_i;
    logic [31:0] w_imm_s;
    logic [31:0] w_imm_b;
    logic [31:0] w_imm_u;
    logic [31:0] w_imm_j;

    assign w_opcode   = in_instr[6:0];
    assign w_funct3   = in_instr[14:12];
    assign w_funct7   = in_instr[31:25];
    // instr[25] is shamt[5] on RV64; on RV32 it must be zero for immediate shifts.
    assign w_shift_hi = in_instr[31:26];
    assign w_shamt_ok = !((XLEN == 32) && in_instr[25]);

    assign w_imm_i = {{20{in_instr[31]}}, in_instr[31:20]};
    assign w_imm_s = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
    assign w_imm_b = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
    assign w_imm_u = {in_instr[31:12], 12'h000};
    assign w_imm_j = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};

    class_e      w_cls;
    logic        w_legal;
    logic        w_has_rd;
    logic        w_has_rs1;
    logic        w_has_rs2;
    logic        w_alt;
    logic        w_muldiv;
    logic [31:0] w_imm32;
    entry_t      w_dec;

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        w_cls     = CL_ILLEGAL;
        w_legal   = 1'b0;
        w_has_rd  = 1'b0;
        w_has_rs1 = 1'b0;
        w_has_rs2 = 1'b0;
        w_alt     = 1'b0;
        w_muldiv  = 1'b0;
        w_imm32   = 32'h0;
        unique case (w_opcode)
            OPC_LUI, OPC_AUIPC: begin
                w_cls    = (w_opcode == OPC_LUI) ? CL_LUI : CL_AUIPC;
                w_legal  = 1'b1;
                w_has_rd = 1'b1;
                w_imm32  = w_imm_u;
            end
            OPC_JAL: begin
                w_cls    = CL_JAL;
                w_legal  = 1'b1;
                w_has_rd = 1'b1;
                w_imm32  = w_imm_j;
            end
            OPC_JALR: begin
                w_cls     = CL_JALR;
                w_legal   = (w_funct3 == 3'b000);
                w_has_rd  = 1'b1;
                w_has_rs1 = 1'b1;
                w_imm32   = w_imm_i;
            end
            OPC_BRANCH: begin
                w_cls     = CL_BRANCH;
                w_legal   = (w_funct3[2:1] != 2'b01);
                w_has_rs1 = 1'b1;
                w_has_rs2 = 1'b1;
                w_imm32   = w_imm_b;
            end
            OPC_LOAD: begin
                w_cls     = CL_LOAD;
                w_legal   = !((w_funct3 == 3'b011) || (w_funct3[2:1] == 2'b11));
                w_has_rd  = 1'b1;
                w_has_rs1 = 1'b1;
                w_imm32   = w_imm_i;
            end
            OPC_STORE: begin
                w_cls     = CL_STORE;
                w_legal   = (w_funct3 < 3'b011);
                w_has_rs1 = 1'b1;
                w_has_rs2 = 1'b1;
                w_imm32   = w_imm_s;
            end
            OPC_OP_IMM: begin
                w_cls     = CL_OP_IMM;
                w_has_rd  = 1'b1;
                w_has_rs1 = 1'b1;
                w_imm32   = w_imm_i;
                if (w_funct3 == 3'b001) begin
                    w_legal = (w_shift_hi == 6'b000000) && w_shamt_ok;
                end else if (w_funct3 == 3'b101) begin
                    w_legal = ((w_shift_hi == 6'b000000) || (w_shift_hi == 6'b010000)) && w_shamt_ok;
                    w_alt   = in_instr[30];
                end else begin
                    w_legal = 1'b1;
                end
            end
            OPC_OP: begin
                w_cls     = CL_OP;
                w_has_rd  = 1'b1;
                w_has_rs1 = 1'b1;
                w_has_rs2 = 1'b1;
                if (w_funct7 == 7'b0000000) begin
                    w_legal = 1'b1;
                end else if (w_funct7 == 7'b0100000) begin
                    w_legal = (w_funct3 == 3'b000) || (w_funct3 == 3'b101);
                    w_alt   = 1'b1;
                end else if (w_funct7 == 7'b0000001) begin
                    w_legal  = ENABLE_M;
                    w_muldiv = 1'b1;
                end
            end
            OPC_FENCE: begin
                w_cls     = CL_FENCE;
                w_legal   = 1'b1;
                w_has_rd  = 1'b1;
                w_has_rs1 = 1'b1;
            end
            OPC_SYSTEM: begin
                w_cls     = CL_SYSTEM;
                w_legal   = (in_instr == 32'h0000_0073) || (in_instr == 32'h0010_0073);
                w_has_rd  = 1'b1;
                w_has_rs1 = 1'b1;
            end
            default: ;
        endcase
    end

    // Illegal entries keep every raw register field but carry no immediate.
    always_comb begin
        w_dec.pc        = in_pc;
        w_dec.funct3    = w_funct3;
        w_dec.illegal   = !w_legal;
        w_dec.cls       = w_legal ? w_cls : CL_ILLEGAL;
        w_dec.rd        = (!w_legal || w_has_rd)  ? in_instr[11:7]  : 5'd0;
        w_dec.rs1       = (!w_legal || w_has_rs1) ? in_instr[19:15] : 5'd0;
        w_dec.rs2       = (!w_legal || w_has_rs2) ? in_instr[24:20] : 5'd0;
        w_dec.imm       = w_legal ? XLEN'($signed(w_imm32)) : '0;
        w_dec.alu_alt   = w_legal && w_alt;
        w_dec.alu_src   = !(w_legal && ((w_cls == CL_OP) || (w_cls == CL_BRANCH)));
        w_dec.is_muldiv = w_legal && w_muldiv;
    end

    entry_t r_out;
    entry_t r_skid;
    logic   r_out_valid;
    logic   r_skid_valid;
    logic   w_accept;
    logic   w_push;
    logic   w_drain;

    assign w_accept = in_valid && !r_skid_valid;
    assign w_push   = w_accept && (PASS_ILLEGAL || w_legal);
    assign w_drain  = r_out_valid && out_ready;

    // NOTE: payload registers are reset too, so every data output reads 0 during reset.
    // NOTE: state updates use non-blocking assignments so the skid->output move sees old values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid  <= 1'b0;
            r_skid_valid <= 1'b0;
            r_out        <= '0;
            r_skid       <= '0;
        end else if (flush) begin
            r_out_valid  <= 1'b0;
            r_skid_valid <= 1'b0;
        end else if (w_drain || !r_out_valid) begin
            if (r_skid_valid) begin
                r_out        <= r_skid;
                r_out_valid  <= 1'b1;
                r_skid_valid <= 1'b0;
            end else begin
                r_out_valid <= w_push;
                if (w_push) begin
                    r_out <= w_dec;
                end
            end
        end else if (w_push) begin
            r_skid       <= w_dec;
            r_skid_valid <= 1'b1;
        end
    end

    assign in_ready      = !r_skid_valid;
    assign out_valid     = r_out_valid;
    assign out_pc        = r_out.pc;
    assign out_rd        = r_out.rd;
    assign out_rs1       = r_out.rs1;
    assign out_rs2       = r_out.rs2;
    assign out_imm       = r_out.imm;
    assign out_class     = r_out.cls;
    assign out_funct3    = r_out.funct3;
    assign out_alu_alt   = r_out.alu_alt;
    assign out_alu_src   = r_out.alu_src;
    assign out_is_muldiv = r_out.is_muldiv;
    assign out_illegal   = r_out.illegal;

endmodule

// File: tb/tb_rv_decode_stage.sv
// tb_rv_decode_stage: table vectors, handshake corner sequences and randomized streaming
// against a queue-based reference model, on a default instance and an M / drop-illegal instance.
module tb_rv_decode_stage;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic [3:0]  cls;
        logic [2:0]  f3;
        logic        alt;
        logic        src;
        logic        md;
        logic        ill;
    } exp_t;

    typedef struct {
        logic [31:0] instr;
        exp_t        exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] in_instr = 32'h0;
    logic [31:0] in_pc = 32'h0;

    logic        rdy1, vld1, alt1, src1, md1, ill1;
    logic [31:0] pc1, imm1;
    logic [4:0]  rd1, rs11, rs21;
    logic [3:0]  cls1;
    logic [2:0]  f31;

    logic        rdy2, vld2, alt2, src2, md2, ill2;
    logic [31:0] pc2, imm2;
    logic [4:0]  rd2, rs12, rs22;
    logic [3:0]  cls2;
    logic [2:0]  f32;

    int n_tests = 0;
    int n_fail = 0;
    exp_t q1[$];
    exp_t q2[$];
    vec_t tbl[20];

    always #5 clk = ~clk;

    rv_decode_stage #(.XLEN(32), .ENABLE_M(1'b0), .PASS_ILLEGAL(1'b1)) u_dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(rdy1), .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(vld1), .out_ready(out_ready), .out_pc(pc1),
        .out_rd(rd1), .out_rs1(rs11), .out_rs2(rs21), .out_imm(imm1),
        .out_class(cls1), .out_funct3(f31), .out_alu_alt(alt1), .out_alu_src(src1),
        .out_is_muldiv(md1), .out_illegal(ill1)
    );

    rv_decode_stage #(.XLEN(32), .ENABLE_M(1'b1), .PASS_ILLEGAL(1'b0)) u_dut_m (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(rdy2), .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(vld2), .out_ready(out_ready), .out_pc(pc2),
        .out_rd(rd2), .out_rs1(rs12), .out_rs2(rs22), .out_imm(imm2),
        .out_class(cls2), .out_funct3(f32), .out_alu_alt(alt2), .out_alu_src(src2),
        .out_is_muldiv(md2), .out_illegal(ill2)
    );

    function automatic exp_t mk(input logic [31:0] pc, input logic [4:0] rd, input logic [4:0] rs1,
                                input logic [4:0] rs2, input logic [31:0] imm, input logic [3:0] cls,
                                input logic [2:0] f3, input logic alt, input logic src,
                                input logic md, input logic ill);
        exp_t e;
        e.pc = pc; e.rd = rd; e.rs1 = rs1; e.rs2 = rs2; e.imm = imm; e.cls = cls;
        e.f3 = f3; e.alt = alt; e.src = src; e.md = md; e.ill = ill;
        return e;
    endfunction

    function automatic exp_t act1();
        return mk(pc1, rd1, rs11, rs21, imm1, cls1, f31, alt1, src1, md1, ill1);
    endfunction

    function automatic exp_t act2();
        return mk(pc2, rd2, rs12, rs22, imm2, cls2, f32, alt2, src2, md2, ill2);
    endfunction

    // Reference decode: class and format from the opcode, then the legality rules.
    function automatic exp_t ref_decode(input logic [31:0] ins, input logic [31:0] pc, input bit en_m);
        exp_t e;
        int   cls;
        int   v;
        bit   ok;
        bit   md;
        byte  fmt;
        logic [2:0] f3 = ins[14:12];
        logic [6:0] f7 = ins[31:25];
        ok = 1'b1; md = 1'b0; cls = 15; fmt = "N"; v = 0;
        case (ins[6:0])
            7'h37: begin cls = 0;  fmt = "U"; end
            7'h17: begin cls = 1;  fmt = "U"; end
            7'h6F: begin cls = 2;  fmt = "J"; end
            7'h67: begin cls = 3;  fmt = "I"; ok = (f3 == 0); end
            7'h63: begin cls = 4;  fmt = "B"; ok = !(f3 == 2 || f3 == 3); end
            7'h03: begin cls = 5;  fmt = "I"; ok = !(f3 == 3 || f3 == 6 || f3 == 7); end
            7'h23: begin cls = 6;  fmt = "S"; ok = (f3 < 3); end
            7'h13: begin
                cls = 7; fmt = "I";
                if (f3 == 1) ok = (f7 == 0);
                else if (f3 == 5) ok = (f7 == 7'h00 || f7 == 7'h20);
            end
            7'h33: begin
                cls = 8; fmt = "R";
                if (f7 == 7'h20) ok = (f3 == 0 || f3 == 5);
                else if (f7 == 7'h01) begin ok = en_m; md = 1'b1; end
                else ok = (f7 == 7'h00);
            end
            7'h0F: begin cls = 9;  fmt = "F"; end
            7'h73: begin cls = 10; fmt = "N"; ok = (ins == 32'h73 || ins == 32'h0010_0073); end
            default: ok = 1'b0;
        endcase
        e = '0;
        e.pc = pc;
        e.f3 = f3;
        if (!ok) begin
            e.cls = 4'd15; e.ill = 1'b1; e.src = 1'b1;
            e.rd = ins[11:7]; e.rs1 = ins[19:15]; e.rs2 = ins[24:20];
            return e;
        end
        case (fmt)
            "I": v = $signed(ins[31:20]);
            "S": v = $signed({ins[31:25], ins[11:7]});
            "B": v = $signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0});
            "U": v = {ins[31:12], 12'h000};
            "J": v = $signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0});
            default: v = 0;
        endcase
        e.imm = v;
        e.cls = 4'(cls);
        if (fmt == "U" || fmt == "J" || fmt == "I" || fmt == "R" || fmt == "F") e.rd = ins[11:7];
        if (fmt == "I" || fmt == "S" || fmt == "B" || fmt == "R" || fmt == "F") e.rs1 = ins[19:15];
        if (fmt == "S" || fmt == "B" || fmt == "R") e.rs2 = ins[24:20];
        e.alt = ((cls == 7 && f3 == 5) || (cls == 8 && (f3 == 0 || f3 == 5))) ? ins[30] : 1'b0;
        e.src = !(cls == 8 || cls == 4);
        e.md = md;
        return e;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] r = $urandom;
        logic [6:0]  op;
        if ($urandom_range(0, 19) == 0) return r;
        case ($urandom_range(0, 10))
            0: op = 7'h37;  1: op = 7'h17;  2: op = 7'h6F;  3: op = 7'h67;
            4: op = 7'h63;  5: op = 7'h03;  6: op = 7'h23;  7: op = 7'h13;
            8: op = 7'h33;  9: op = 7'h0F;  default: op = 7'h73;
        endcase
        r[6:0] = op;
        if (op == 7'h33) begin
            case ($urandom_range(0, 3))
                0: r[31:25] = 7'h00;  1: r[31:25] = 7'h20;  2: r[31:25] = 7'h01;  default: ;
            endcase
        end else if (op == 7'h13 && r[13:12] == 2'b01) begin
            case ($urandom_range(0, 2))
                0: r[31:25] = 7'h00;  1: r[31:25] = 7'h20;  default: ;
            endcase
        end else if (op == 7'h73) begin
            case ($urandom_range(0, 2))
                0: r = 32'h0000_0073;  1: r = 32'h0010_0073;  default: ;
            endcase
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                         input logic rdy, input logic fl);
        in_valid = v; in_instr = ins; in_pc = pc; out_ready = rdy; flush = fl;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        tbl[0]  = '{32'hFFF0_0093, mk(32'h100, 1, 0, 0, 32'hFFFF_FFFF, 7,  0, 0, 1, 0, 0)};
        tbl[1]  = '{32'h4020_81B3, mk(32'h104, 3, 1, 2, 32'h0,         8,  0, 1, 0, 0, 0)};
        tbl[2]  = '{32'hFE00_0EE3, mk(32'h108, 0, 0, 0, 32'hFFFF_FFFC, 4,  0, 0, 0, 0, 0)};
        tbl[3]  = '{32'h0273_02B3, mk(32'h10C, 5, 6, 7, 32'h0,         15, 0, 0, 1, 0, 1)};
        tbl[4]  = '{32'h0000_0010, mk(32'h110, 0, 0, 0, 32'h0,         15, 0, 0, 1, 0, 1)};
        tbl[5]  = '{32'h1234_52B7, mk(32'h114, 5, 0, 0, 32'h1234_5000, 0,  5, 0, 1, 0, 0)};
        tbl[6]  = '{32'h0080_00EF, mk(32'h118, 1, 0, 0, 32'h8,         2,  0, 0, 1, 0, 0)};
        tbl[7]  = '{32'h0000_0073, mk(32'h11C, 0, 0, 0, 32'h0,         10, 0, 0, 1, 0, 0)};
        tbl[8]  = '{32'h0010_0073, mk(32'h120, 0, 0, 0, 32'h0,         10, 0, 0, 1, 0, 0)};
        tbl[9]  = '{32'h0020_A623, mk(32'h124, 0, 1, 2, 32'hC,         6,  2, 0, 1, 0, 0)};
        tbl[10] = '{32'h4032_5213, mk(32'h128, 4, 4, 0, 32'h403,       7,  5, 1, 1, 0, 0)};
        tbl[11] = '{32'h0200_9093, mk(32'h12C, 1, 1, 0, 32'h0,         15, 1, 0, 1, 0, 1)};
        tbl[12] = '{32'hFF81_2183, mk(32'h130, 3, 2, 0, 32'hFFFF_FFF8, 5,  2, 0, 1, 0, 0)};
        tbl[13] = '{32'h0001_3183, mk(32'h134, 3, 2, 0, 32'h0,         15, 3, 0, 1, 0, 1)};
        tbl[14] = '{32'hFFFF_F397, mk(32'h138, 7, 0, 0, 32'hFFFF_F000, 1,  7, 0, 1, 0, 0)};
        tbl[15] = '{32'h0FF0_000F, mk(32'h13C, 0, 0, 0, 32'h0,         9,  0, 0, 1, 0, 0)};
        tbl[16] = '{32'h4020_90B3, mk(32'h140, 1, 1, 2, 32'h0,         15, 1, 0, 1, 0, 1)};
        tbl[17] = '{32'h0000_90E7, mk(32'h144, 1, 1, 0, 32'h0,         15, 1, 0, 1, 0, 1)};
        tbl[18] = '{32'h0020_C863, mk(32'h148, 0, 1, 2, 32'h10,        4,  4, 0, 0, 0, 0)};
        tbl[19] = '{32'h0011_5113, mk(32'h14C, 2, 2, 0, 32'h1,         7,  5, 0, 1, 0, 0)};

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", vld1, 1'b0);
        check("rst_in_ready", rdy1, 1'b1);
        check("rst_payload", act1(), '0);
        rst = 1'b0;
        step();

        // Single-instruction vectors, one accept then one drain each.
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, tbl[i].instr, tbl[i].exp.pc, 1'b1, 1'b0);
            step();
            drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
            check($sformatf("vec%0d_valid", i), vld1, 1'b1);
            check($sformatf("vec%0d_fields", i), act1(), tbl[i].exp);
            step();
        end
        check("vec_drained", vld1, 1'b0);

        // Backpressure: two accepted, third stalls, outputs hold, then three back-to-back.
        drive(1'b1, tbl[0].instr, tbl[0].exp.pc, 1'b0, 1'b0);
        step();
        check("bp_ready_after1", rdy1, 1'b1);
        drive(1'b1, tbl[1].instr, tbl[1].exp.pc, 1'b0, 1'b0);
        step();
        check("bp_ready_after2", rdy1, 1'b0);
        drive(1'b1, tbl[2].instr, tbl[2].exp.pc, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            step();
            check($sformatf("bp_hold%0d_ready", k), rdy1, 1'b0);
            check($sformatf("bp_hold%0d_out", k), act1(), tbl[0].exp);
        end
        out_ready = 1'b1;
        step();
        check("bp_rel1_valid", vld1, 1'b1);
        check("bp_rel1_out", act1(), tbl[1].exp);
        check("bp_rel1_ready", rdy1, 1'b1);
        step();
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        check("bp_rel2_valid", vld1, 1'b1);
        check("bp_rel2_out", act1(), tbl[2].exp);
        step();
        check("bp_empty", vld1, 1'b0);

        // Flush with two buffered and a new offer: nothing survives.
        drive(1'b1, tbl[5].instr, tbl[5].exp.pc, 1'b0, 1'b0);
        step();
        drive(1'b1, tbl[6].instr, tbl[6].exp.pc, 1'b0, 1'b0);
        step();
        drive(1'b1, tbl[9].instr, tbl[9].exp.pc, 1'b0, 1'b1);
        step();
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        check("flush_valid", vld1, 1'b0);
        check("flush_ready", rdy1, 1'b1);
        for (int k = 0; k < 3; k++) begin
            step();
            check($sformatf("flush_quiet%0d", k), vld1, 1'b0);
        end
        // Flush alongside a real handshake: the accepted entry is discarded too.
        drive(1'b1, tbl[5].instr, tbl[5].exp.pc, 1'b0, 1'b0);
        step();
        drive(1'b1, tbl[6].instr, tbl[6].exp.pc, 1'b1, 1'b1);
        step();
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        check("flush_hs_valid", vld1, 1'b0);
        step();
        check("flush_hs_quiet", vld1, 1'b0);

        // M-enabled, drop-illegal instance.
        drive(1'b1, 32'h0273_02B3, 32'h200, 1'b1, 1'b0);
        step();
        check("m_mul_valid", vld2, 1'b1);
        check("m_mul_fields", act2(), mk(32'h200, 5, 6, 7, 32'h0, 8, 0, 0, 0, 1, 0));
        check("nom_mul_illegal", act1(), mk(32'h200, 5, 6, 7, 32'h0, 15, 0, 0, 1, 0, 1));
        drive(1'b1, 32'h0000_0010, 32'h204, 1'b1, 1'b0);
        step();
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        check("drop_valid", vld2, 1'b0);
        check("drop_ready", rdy2, 1'b1);
        check("pass_illegal", ill1, 1'b1);
        step();
        check("drop_quiet", vld2, 1'b0);

        // Asynchronous reset with both entries full.
        drive(1'b1, tbl[0].instr, tbl[0].exp.pc, 1'b0, 1'b0);
        step();
        drive(1'b1, tbl[1].instr, tbl[1].exp.pc, 1'b0, 1'b0);
        step();
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        #2 rst = 1'b1;
        #1;
        check("arst_valid", vld1, 1'b0);
        check("arst_ready", rdy1, 1'b1);
        check("arst_payload", act1(), '0);
        step();
        rst = 1'b0;
        step();
        check("arst_after", vld1, 1'b0);

        // Randomized streaming against the queue model, both instances.
        for (int c = 0; c < 3000; c++) begin
            bit acc1, acc2, drn1, drn2;
            exp_t e1, e2;
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 40) == 0);
            in_instr  = rand_instr();
            in_pc     = $urandom & 32'hFFFF_FFFC;
            @(negedge clk);
            check("rnd_ready1", rdy1, q1.size() < 2);
            check("rnd_valid1", vld1, q1.size() != 0);
            if (q1.size() != 0) check("rnd_out1", act1(), q1[0]);
            check("rnd_ready2", rdy2, q2.size() < 2);
            check("rnd_valid2", vld2, q2.size() != 0);
            if (q2.size() != 0) check("rnd_out2", act2(), q2[0]);
            acc1 = in_valid && (q1.size() < 2);
            acc2 = in_valid && (q2.size() < 2);
            drn1 = out_ready && (q1.size() != 0);
            drn2 = out_ready && (q2.size() != 0);
            e1 = ref_decode(in_instr, in_pc, 1'b0);
            e2 = ref_decode(in_instr, in_pc, 1'b1);
            @(posedge clk);
            if (flush) begin
                q1.delete();
                q2.delete();
            end else begin
                if (drn1) void'(q1.pop_front());
                if (drn2) void'(q2.pop_front());
                if (acc1) q1.push_back(e1);
                if (acc2 && !e2.ill) q2.push_back(e2);
            end
            #1;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
